snn_lif_core: RTL

SNN_LIF_CORE -- requirements
Module: snn_lif_core

---
 rtl/snn_pkg.sv | 22 ++
 rtl/snn_sat_add.sv | 32 +++
 rtl/snn_lif_core.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// Shared definitions for the LIF spiking-neuron core.
// Holds parameter defaults, the weight width, the weight-address width and
// the controller state encoding used by snn_lif_core.
package snn_pkg;

  localparam int N_IN_DEF       = 8;
  localparam int N_OUT_DEF      = 2;
  localparam int VW_DEF         = 12;
  localparam int THRESH_DEF     = 256;
  localparam int LEAK_SHIFT_DEF = 3;

  // Signed weight width and weight-address width ({neuron, input_idx}).
  localparam int WW = 8;
  localparam int AW = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_UPDATE = 2'd2
  } state_e;

endpackage

// File: rtl/snn_sat_add.sv
// Saturating signed accumulate for one neuron's membrane potential.
// Ports:
//   a  - current potential (VW-bit signed)
//   b  - weight (WW-bit signed), sign-extended before the add
//   en - when low the potential passes through unchanged
//   y  - a + b clamped to [-2^(VW-1), 2^(VW-1)-1], or a when en is low
module snn_sat_add #(
  parameter int VW = 12,
  parameter int WW = 8
) (
  input  logic [VW-1:0] a,
  input  logic [WW-1:0] b,
  input  logic          en,
  output logic [VW-1:0] y
);

  logic [VW:0] sum;

  // One guard bit: the sum overflowed iff the top two bits disagree.
  assign sum = {a[VW-1], a} + {{(VW+1-WW){b[WW-1]}}, b};

  always_comb begin
    y = a;
    if (en) begin
      if (sum[VW] != sum[VW-1])
        y = sum[VW] ? {1'b1, {(VW-1){1'b0}}} : {1'b0, {(VW-1){1'b1}}};
      else
        y = sum[VW-1:0];
    end
  end

endmodule

// File: rtl/snn_lif_core.sv
// Leaky integrate-and-fire core: N_OUT neurons, each fed by N_IN spike lines.
// A step sweeps all weights from an external registered-read memory,
// accumulating the weight of every active input into its neuron's potential,
// then applies leak and threshold.
// Ports:
//   clk, rst_n  - rising-edge clock, synchronous active-low reset
//   start       - request a step (taken only when idle)
//   spike_vec   - input spikes, latched when start is taken
//   w_addr      - weight address {neuron, input_idx}; 0 while idle
//   w_rdata     - signed weight, valid the cycle after its address
//   busy        - step in progress
//   done        - one-cycle completion pulse
//   spike_out   - fire flags of the last completed step
// Address layout assumes N_IN is a power of two and N_IN*N_OUT == 16.
module snn_lif_core
  import snn_pkg::*;
#(
  parameter int N_IN       = N_IN_DEF,
  parameter int N_OUT      = N_OUT_DEF,
  parameter int VW         = VW_DEF,
  parameter int THRESH     = THRESH_DEF,
  parameter int LEAK_SHIFT = LEAK_SHIFT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N_IN-1:0]  spike_vec,
  output logic [3:0]       w_addr,
  input  logic [7:0]       w_rdata,
  output logic             busy,
  output logic             done,
  output logic [N_OUT-1:0] spike_out
);

  localparam int NW  = N_IN * N_OUT;
  localparam int IW  = $clog2(N_IN);
  localparam int NSW = AW - IW;
  localparam logic signed [VW-1:0] TH = VW'(THRESH);
  localparam logic [AW-1:0] LAST = AW'(NW - 1);

  state_e                  state_q, state_d;
  logic [AW-1:0]           idx_q, idx_d;
  logic                    issued_q, issued_d;   // every address has been presented
  logic                    rd_vld_q, rd_vld_d;   // w_rdata carries a weight this cycle
  logic [AW-1:0]           rd_addr_q, rd_addr_d; // address that weight belongs to
  logic [N_IN-1:0]         spk_q, spk_d;
  logic [N_OUT-1:0][VW-1:0] v_q, v_d;
  logic [N_OUT-1:0]        spike_q, spike_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic [N_OUT-1:0]        add_en;
  logic [N_OUT-1:0][VW-1:0] sum;
  logic [N_OUT-1:0][VW-1:0] vl;
  logic [N_OUT-1:0]        fire;

  for (genvar n = 0; n < N_OUT; n++) begin : g_nrn
    // Only the neuron owning the returning weight accumulates, and only if
    // that weight's input line spiked.
    assign add_en[n] = rd_vld_q && (state_q == ST_FETCH) &&
                       (rd_addr_q[AW-1:IW] == NSW'(n)) &&
                       spk_q[rd_addr_q[IW-1:0]];

    snn_sat_add #(.VW(VW), .WW(WW)) u_add (
      .a  (v_q[n]),
      .b  (w_rdata),
      .en (add_en[n]),
      .y  (sum[n])
    );

    // Leak cannot overflow: |v - (v >>> k)| never exceeds |v| for k >= 1.
    assign vl[n]   = $signed(v_q[n]) - ($signed(v_q[n]) >>> LEAK_SHIFT);
    assign fire[n] = $signed(vl[n]) >= TH;
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    issued_d  = issued_q;
    rd_vld_d  = 1'b0;
    rd_addr_d = idx_q;
    spk_d     = spk_q;
    v_d       = v_q;
    spike_d   = spike_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        if (start) begin
          spk_d    = spike_vec;
          busy_d   = 1'b1;
          issued_d = 1'b0;
          state_d  = ST_FETCH;
        end
      end
      ST_FETCH: begin
        v_d = sum;
        if (!issued_q) begin
          rd_vld_d = 1'b1;
          // Hold the last address rather than wrapping while its data returns.
          if (idx_q == LAST) issued_d = 1'b1;
          else               idx_d    = idx_q + 1'b1;
        end
        if (rd_vld_q && rd_addr_q == LAST) begin
          idx_d   = '0;
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        for (int n = 0; n < N_OUT; n++) begin
          spike_d[n] = fire[n];
          v_d[n]     = fire[n] ? '0 : vl[n];
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      issued_q  <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_addr_q <= '0;
      spk_q     <= '0;
      v_q       <= '0;
      spike_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      issued_q  <= issued_d;
      rd_vld_q  <= rd_vld_d;
      rd_addr_q <= rd_addr_d;
      spk_q     <= spk_d;
      v_q       <= v_d;
      spike_q   <= spike_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign w_addr    = idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign spike_out = spike_q;

endmodule
